// File: rtl/uart_axi_cmd_sequencer.sv
// Executes one parsed UART host frame as LEN+1 single-beat AXI4-Lite transfers.
// Define UART_AXI_SEQ_TIMEOUT_EN to abort stalled AXI handshakes after AXI_TIMEOUT_CLOCKS.
module uart_axi_cmd_sequencer #(
    parameter int AXI_TIMEOUT_CLOCKS = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  cmd,
    input  logic [31:0] addr,
    input  logic [7:0]  data_in [64],
    input  logic        frame_valid,
    input  logic        frame_error,
    input  logic [7:0]  error_status,
    output logic        frame_consumed,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] rd_data,
    output logic        rd_data_valid,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [7:0]  resp_status,
    output logic [7:0]  resp_cmd,
    output logic [4:0]  resp_beats,
    output logic        busy
);

    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_SIZE    = 8'h02;
    localparam logic [7:0] ST_ALIGN   = 8'h03;
    localparam logic [7:0] ST_TIMEOUT = 8'h04;
    localparam logic [7:0] ST_SLVERR  = 8'h05;

    typedef enum logic [2:0] {
        IDLE, CHECK, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, RESP, CONSUME
    } state_t;

    state_t      state, state_n;
    logic [31:0] beat_addr;
    logic [5:0]  byte_idx;
    logic        aw_done, w_done;
    logic        aw_fire, w_fire;
    logic [2:0]  beat_bytes;
    logic [7:0]  check_status;
    logic        last_beat;
    logic        wr_ok, rd_ok, beat_ok, beat_err;
    logic        tmo_hit;
    logic [1:0]  lane;

    // resp_cmd doubles as the latched command for the whole frame
    assign last_beat = (resp_beats[3:0] == resp_cmd[3:0]);

    assign awaddr         = beat_addr;
    assign araddr         = beat_addr;
    assign awvalid        = (state == WR_ADDR) && !aw_done;
    assign wvalid         = (state == WR_ADDR) && !w_done;
    assign bready         = (state == WR_RESP);
    assign arvalid        = (state == RD_ADDR);
    assign rready         = (state == RD_DATA);
    assign resp_valid     = (state == RESP);
    assign frame_consumed = (state == CONSUME);
    assign busy           = (state != IDLE);

    assign aw_fire  = awvalid && awready;
    assign w_fire   = wvalid && wready;
    assign wr_ok    = (state == WR_RESP) && bvalid && (bresp == 2'b00);
    assign rd_ok    = (state == RD_DATA) && rvalid && (rresp == 2'b00);
    assign beat_ok  = wr_ok || rd_ok;
    assign beat_err = ((state == WR_RESP) && bvalid && (bresp != 2'b00)) ||
                      ((state == RD_DATA) && rvalid && (rresp != 2'b00));

    always_comb begin
        beat_bytes = 3'd1;
        case (resp_cmd[5:4])
            2'b01:   beat_bytes = 3'd2;
            2'b10:   beat_bytes = 3'd4;
            default: beat_bytes = 3'd1;
        endcase
    end

    always_comb begin
        check_status = ST_OK;
        case (resp_cmd[5:4])
            2'b11:   check_status = ST_SIZE;
            2'b10:   if (beat_addr[1:0] != 2'b00) check_status = ST_ALIGN;
            2'b01:   if (beat_addr[0]) check_status = ST_ALIGN;
            default: check_status = ST_OK;
        endcase
    end

    // Beat bytes land in the byte lanes selected by the low address bits
    always_comb begin
        wdata = '0;
        wstrb = '0;
        lane  = '0;
        for (int j = 0; j < 4; j++) begin
            if (j < int'(beat_bytes)) begin
                lane = beat_addr[1:0] + 2'(j);
                wdata[{lane, 3'b000} +: 8] = data_in[byte_idx + 6'(j)];
                wstrb[lane] = 1'b1;
            end
        end
    end

`ifdef UART_AXI_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(AXI_TIMEOUT_CLOCKS + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             axi_wait;

    assign axi_wait = (state == WR_ADDR) || (state == WR_RESP) ||
                      (state == RD_ADDR) || (state == RD_DATA);
    assign tmo_hit  = axi_wait && (tmo_cnt == TMO_W'(AXI_TIMEOUT_CLOCKS - 1));

    always_ff @(posedge clk) begin
        if (rst || (state_n != state) || !axi_wait) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^AXI_TIMEOUT_CLOCKS;
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (frame_error) begin
                    state_n = RESP;
                end else if (frame_valid) begin
                    state_n = CHECK;
                end
            end
            CHECK: begin
                if (check_status != ST_OK) begin
                    state_n = RESP;
                end else if (resp_cmd[7]) begin
                    state_n = RD_ADDR;
                end else begin
                    state_n = WR_ADDR;
                end
            end
            WR_ADDR: if ((aw_done || aw_fire) && (w_done || w_fire)) state_n = WR_RESP;
            WR_RESP: if (bvalid) state_n = (beat_err || last_beat) ? RESP : WR_ADDR;
            RD_ADDR: if (arready) state_n = RD_DATA;
            RD_DATA: if (rvalid) state_n = (beat_err || last_beat) ? RESP : RD_ADDR;
            RESP:    if (resp_ready) state_n = CONSUME;
            CONSUME: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (tmo_hit) begin
            state_n = RESP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_addr     <= '0;
            byte_idx      <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            rd_data       <= '0;
            rd_data_valid <= 1'b0;
            resp_status   <= '0;
            resp_cmd      <= '0;
            resp_beats    <= '0;
        end else begin
            rd_data_valid <= rd_ok;
            if (rd_ok) begin
                rd_data <= rdata;
            end
            case (state)
                IDLE: begin
                    if (frame_error) begin
                        resp_status <= (error_status == 8'h00) ? ST_TIMEOUT : error_status;
                        resp_cmd    <= cmd;
                        resp_beats  <= '0;
                    end else if (frame_valid) begin
                        resp_cmd    <= cmd;
                        beat_addr   <= addr;
                        byte_idx    <= '0;
                        resp_beats  <= '0;
                    end
                end
                CHECK: begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    if (check_status != ST_OK) begin
                        resp_status <= check_status;
                    end
                end
                WR_ADDR: begin
                    if (aw_fire) aw_done <= 1'b1;
                    if (w_fire) w_done <= 1'b1;
                end
                default: ;
            endcase
            // A completed beat moves the address and payload pointer to the next one
            if (beat_ok) begin
                resp_beats <= resp_beats + 5'd1;
                beat_addr  <= resp_cmd[6] ? beat_addr + 32'(beat_bytes) : beat_addr;
                byte_idx   <= byte_idx + 6'(beat_bytes);
                aw_done    <= 1'b0;
                w_done     <= 1'b0;
                if (last_beat) begin
                    resp_status <= ST_OK;
                end
            end
            if (beat_err) begin
                resp_status <= ST_SLVERR;
            end
            if (tmo_hit) begin
                resp_status <= ST_TIMEOUT;
            end
        end
    end

endmodule

// File: doc/uart_axi_cmd_sequencer.md
Name: uart_axi_cmd_sequencer

Overview:
- Sits between the UART frame parser and the AXI4-Lite master port of the UART-AXI4 bridge.
- Takes one parsed host frame and checks address alignment. It then runs LEN+1 single-beat AXI4-Lite write or read transactions, with incrementing or fixed address.
- Streams read data to the response path and reports one completion status per frame.
- Pulses frame_consumed so the parser can release the frame.

Parameters:
- AXI_TIMEOUT_CLOCKS, 4096, max cycles waiting on any single AXI channel handshake before aborting (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd  in  8  parsed command: [7]=RW (1=read), [6]=INC, [5:4]=SIZE, [3:0]=LEN
- addr  in  32  parsed start address
- data_in  in  8 x64 unpacked array  write payload bytes, index 0 first
- frame_valid  in  1  parsed frame ready, no error
- frame_error  in  1  parsed frame failed
- error_status  in  8  parser status code
- frame_consumed  out  1  one-cycle pulse, frame released
- awaddr/awvalid/awready  out/out/in  32/1/1  AXI write address channel
- wdata/wstrb/wvalid/wready  out/out/out/in  32/4/1/1  AXI write data channel
- bresp/bvalid/bready  in/in/out  2/1/1  AXI write response channel
- araddr/arvalid/arready  out/out/in  32/1/1  AXI read address channel
- rdata/rresp/rvalid/rready  in/in/in/out  32/2/1/1  AXI read data channel
- rd_data  out  32  read beat data, lane-aligned
- rd_data_valid  out  1  one-cycle strobe per good read beat; no backpressure
- resp_valid  out  1  completion valid, held until resp_ready
- resp_ready  in  1  response builder accepts completion
- resp_status  out  8  0x00 OK, 0x03 ADDR_ALIGN, 0x04 TIMEOUT, 0x05 AXI_SLVERR, else parser code
- resp_cmd  out  8  latched cmd
- resp_beats  out  5  beats completed successfully (0..16)
- busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE. All valid/ready outputs 0, frame_consumed=0, rd_data_valid=0. rd_data, resp_status, resp_cmd, resp_beats, awaddr and araddr are 0.
- IDLE
  - frame_valid=1: latch cmd, addr, beat count LEN+1; go to CHECK.
  - frame_error=1 (evaluated first if both are high): latch resp_status = error_status, or 0x04 if error_status==0; go to RESP.
- CHECK (1 cycle)
  - SIZE=11 gives 0x02. SIZE=01 with addr[0]!=0 gives 0x03. SIZE=10 with addr[1:0]!=0 gives 0x03. Any of these goes to RESP.
  - Otherwise go to WR_ADDR if RW=0, or RD_ADDR if RW=1.
  - awvalid or arvalid asserts 2 cycles after frame_valid is sampled.
- Byte width: bytes/beat B = 1, 2 or 4 for SIZE 00, 01 or 10.
- Address stepping: beat address = addr + k*B when INC=1, addr when INC=0. 32-bit add, wraps mod 2^32 with no error.
- WR_ADDR
  - awvalid and wvalid assert together and are held until each handshake independently completes.
  - wdata lane = addr[1:0] of the beat. Beat bytes are data_in[k*B .. k*B+B-1], little-endian, placed into that lane.
  - wstrb = ((1<<B)-1) << addr[1:0].
  - When both handshakes are done, go to WR_RESP with bready=1.
- WR_RESP
  - On bvalid: bresp!=00 gives 0x05 and RESP.
  - Else increment resp_beats; go to the next beat (WR_ADDR) or, on the last beat, set status 0x00 and go to RESP.
- RD_ADDR: arvalid until arready, then RD_DATA with rready=1.
- RD_DATA
  - On rvalid with rresp==00: rd_data = rdata, rd_data_valid pulses the same cycle, beat advance as for writes.
  - rresp!=00 gives 0x05; rd_data_valid is not pulsed.
- RESP
  - resp_valid=1, fields stable until resp_ready.
  - On handshake go to CONSUME.
- CONSUME: frame_consumed=1 for one cycle, then IDLE.
- A frame is never re-executed: frame_valid is ignored outside IDLE.
- Errors abort remaining beats. resp_beats reports beats already completed.
- AXI handshakes follow the spec: valid never drops before ready, and ready may precede valid.
- rst mid-transaction returns to IDLE immediately; the AXI slave is reset with the same rst.

Optional Feature:
- UART_AXI_SEQ_TIMEOUT_EN defined:
  - A counter clears on every state change and counts while in WR_ADDR, WR_RESP, RD_ADDR or RD_DATA.
  - At AXI_TIMEOUT_CLOCKS: status 0x04, all AXI valid/ready deasserted, go to RESP.
- Undefined: no counter; the block waits indefinitely.

Test Plan:
- Write cmd=0x20 (32-bit, 1 beat), addr=0x1000, data 11 22 33 44, immediate slave -> one AW/W with wdata=0x44332211, wstrb=0xF; resp_status=0x00, resp_beats=1; frame_consumed pulses after resp_ready.
- Read cmd=0xC3 (INC, 8-bit, 4 beats), addr=0x2001 -> araddr 0x2001, 0x2002, 0x2003, 0x2004; four rd_data_valid strobes; resp_beats=4, status 0x00.
- Write cmd=0x11 (16-bit, no INC, 2 beats), addr=0x3002 -> both beats to 0x3002 with wstrb=0xC; data bytes 0-1, then 2-3, placed in bits [31:16].
- Read cmd=0xA0, addr=0x4002 -> no AXI activity; resp_status=0x03, resp_beats=0.
- Write 4 beats with slave returning bresp=10 on beat 2 -> beats 3-4 not issued; status 0x05, resp_beats=1.
- frame_error with error_status=0x01 -> no AXI activity; resp_status=0x01. With UART_AXI_SEQ_TIMEOUT_EN and awready stuck low -> status 0x04 after AXI_TIMEOUT_CLOCKS.
